// File: rtl/reg_file_bank_if.sv
// System-controller bus view of the register file bank: access requests,
// write data, and the registered read response.
interface reg_file_bank_if #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDRESS_BITS = 3
);
   logic                    R_REG_EN;
   logic                    W_REG_EN;
   logic [ADDRESS_BITS-1:0] REG_ADDRESS;
   logic [DATA_WIDTH-1:0]   W_REG_DATA;
   logic [DATA_WIDTH-1:0]   R_REG_DATA;
   logic                    R_DATA_VALID;

   modport master (
      output R_REG_EN, W_REG_EN, REG_ADDRESS, W_REG_DATA,
      input  R_REG_DATA, R_DATA_VALID
   );

   modport slave (
      input  R_REG_EN, W_REG_EN, REG_ADDRESS, W_REG_DATA,
      output R_REG_DATA, R_DATA_VALID
   );
endinterface

// File: rtl/reg_file_bank.sv
// Single-port register file with synchronous write, registered read plus
// valid strobe, and words 0..3 exported continuously as configuration taps.
module reg_file_bank #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDRESS_BITS = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   reg_file_bank_if.slave        bus,
   output logic [DATA_WIDTH-1:0] REG0,
   output logic [DATA_WIDTH-1:0] REG1,
   output logic [DATA_WIDTH-1:0] REG2,
   output logic [DATA_WIDTH-1:0] REG3
);
   localparam int DEPTH = 1 << ADDRESS_BITS;

   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t mem_q [DEPTH];
   word_t mem_d [DEPTH];
   word_t rd_data_q;
   word_t rd_data_d;
   logic  rd_vld_q;
   logic  rd_vld_d;

   // Power-on configuration: words 2 and 3 carry the neighbours' default setup.
   function automatic word_t rst_word(input int idx);
      case (idx)
         2:       return word_t'(8'h82);
         3:       return word_t'(8'h20);
         default: return '0;
      endcase
   endfunction

   always_comb begin
      mem_d     = mem_q;
      rd_data_d = rd_data_q;
      rd_vld_d  = 1'b0;
      // A write wins over a simultaneous read; the read is dropped entirely.
      if (bus.W_REG_EN) begin
         mem_d[bus.REG_ADDRESS] = bus.W_REG_DATA;
      end else if (bus.R_REG_EN) begin
         rd_data_d = mem_q[bus.REG_ADDRESS];
         rd_vld_d  = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= rst_word(i);
         end
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
      end
   end

   assign bus.R_REG_DATA   = rd_data_q;
   assign bus.R_DATA_VALID = rd_vld_q;

   assign REG0 = mem_q[0];
   assign REG1 = mem_q[1];
   assign REG2 = mem_q[2];
   assign REG3 = mem_q[3];
endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank: reads push expected data into a queue
// that a negedge monitor drains whenever R_DATA_VALID is seen.
module tb_reg_file_bank;
   logic       CLK;
   logic       RST;
   logic [7:0] reg0, reg1, reg2, reg3;

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] model_rd;

   reg_file_bank_if #(.DATA_WIDTH(8), .ADDRESS_BITS(3)) bus ();

   reg_file_bank #(.DATA_WIDTH(8), .ADDRESS_BITS(3)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .bus  (bus),
      .REG0 (reg0),
      .REG1 (reg1),
      .REG2 (reg2),
      .REG3 (reg3)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      @(negedge CLK);
      bus.R_REG_EN = 1'b0;
      bus.W_REG_EN = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge CLK);
      bus.R_REG_EN    = 1'b0;
      bus.W_REG_EN    = 1'b1;
      bus.REG_ADDRESS = a;
      bus.W_REG_DATA  = d;
   endtask

   task automatic rd(input logic [2:0] a, input logic [7:0] exp);
      @(negedge CLK);
      bus.R_REG_EN    = 1'b1;
      bus.W_REG_EN    = 1'b0;
      bus.REG_ADDRESS = a;
      exp_q.push_back(exp);
   endtask

   // Monitor: pops on valid, otherwise requires the read register to hold.
   initial begin
      model_rd = 8'h00;
      forever begin
         @(negedge CLK);
         if (!RST) begin
            chk("valid_in_reset", {7'd0, bus.R_DATA_VALID}, 8'h00);
            chk("rdata_in_reset", bus.R_REG_DATA, 8'h00);
            model_rd = 8'h00;
         end else if (bus.R_DATA_VALID) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_valid: got data %h expected no strobe", bus.R_REG_DATA);
            end else begin
               model_rd = exp_q.pop_front();
               chk("read_data", bus.R_REG_DATA, model_rd);
            end
         end else begin
            chk("rdata_hold", bus.R_REG_DATA, model_rd);
         end
      end
   end

   initial begin
      RST             = 1'b0;
      bus.R_REG_EN    = 1'b0;
      bus.W_REG_EN    = 1'b0;
      bus.REG_ADDRESS = 3'd0;
      bus.W_REG_DATA  = 8'h00;
      repeat (3) @(negedge CLK);
      #1;
      chk("reg0_rst", reg0, 8'h00);
      chk("reg1_rst", reg1, 8'h00);
      chk("reg2_rst", reg2, 8'h82);
      chk("reg3_rst", reg3, 8'h20);
      @(negedge CLK);
      RST = 1'b1;

      // Reset values readable over the bus
      rd(3'd2, 8'h82);
      idle();
      #1;
      chk("reg2_after", reg2, 8'h82);
      chk("reg3_after", reg3, 8'h20);

      // Write to top address, data register must hold 82
      wr(3'd7, 8'h0F);
      rd(3'd7, 8'h0F);

      // Write FF to addr 1, tap visible next cycle
      wr(3'd1, 8'hFF);
      idle();
      #1;
      chk("reg1_write", reg1, 8'hFF);
      rd(3'd1, 8'hFF);

      // Simultaneous read+write: write lands, no strobe
      @(negedge CLK);
      bus.R_REG_EN    = 1'b1;
      bus.W_REG_EN    = 1'b1;
      bus.REG_ADDRESS = 3'd0;
      bus.W_REG_DATA  = 8'hA5;
      idle();
      #1;
      chk("reg0_rw", reg0, 8'hA5);
      idle();

      // Asynchronous reset in the middle of a write sequence
      wr(3'd5, 8'h3C);
      wr(3'd6, 8'h77);
      #2;
      RST = 1'b0;
      #1;
      chk("async_reg0", reg0, 8'h00);
      chk("async_reg1", reg1, 8'h00);
      chk("async_reg2", reg2, 8'h82);
      chk("async_reg3", reg3, 8'h20);
      chk("async_rdata", bus.R_REG_DATA, 8'h00);
      chk("async_valid", {7'd0, bus.R_DATA_VALID}, 8'h00);
      @(negedge CLK);
      bus.W_REG_EN = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      rd(3'd6, 8'h00);
      rd(3'd5, 8'h00);
      rd(3'd7, 8'h00);
      rd(3'd3, 8'h20);

      // Fill then back-to-back reads over the full range
      wr(3'd0, 8'h10);
      wr(3'd1, 8'h21);
      wr(3'd2, 8'h32);
      wr(3'd3, 8'h43);
      wr(3'd4, 8'h54);
      wr(3'd5, 8'h65);
      wr(3'd6, 8'h76);
      wr(3'd7, 8'h87);
      rd(3'd0, 8'h10);
      rd(3'd1, 8'h21);
      rd(3'd2, 8'h32);
      rd(3'd3, 8'h43);
      rd(3'd4, 8'h54);
      rd(3'd5, 8'h65);
      rd(3'd6, 8'h76);
      rd(3'd7, 8'h87);
      idle();
      #1;
      chk("reg3_fill", reg3, 8'h43);
      repeat (3) idle();

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending reads expected 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
